// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin arbiter serialising ATM deposit/withdraw/enquiry against a shared balance file
module atm_account_arbiter #(
  parameter int NUM_ATM  = 4,
  parameter int ACCOUNTS = 8,
  parameter int BAL_W    = 8,
  parameter int AMT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ATM-1:0]       req,
  input  logic [2*NUM_ATM-1:0]     req_op,
  input  logic [8*NUM_ATM-1:0]     req_card,
  input  logic [AMT_W*NUM_ATM-1:0] req_amount,
  input  logic                     init_we,
  input  logic [7:0]               init_card,
  input  logic [BAL_W-1:0]         init_balance,
  output logic [NUM_ATM-1:0]       grant,
  output logic [NUM_ATM-1:0]       done,
  output logic [1:0]               resp_status,
  output logic [BAL_W-1:0]         resp_balance,
  output logic                     busy
);
  localparam int WW = $clog2(NUM_ATM);
  localparam int IW = $clog2(ACCOUNTS);
  typedef enum logic [2:0] {IDLE, LATCH, READ, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [WW-1:0] p, win, win_n;
  logic [WW:0] k;
  logic found, wr;
  logic [1:0] op, status, st_n;
  logic [7:0] card;
  logic [AMT_W-1:0] amt;
  logic [BAL_W-1:0] work, result, res_n;
  logic [BAL_W:0] sum;
  logic [BAL_W-1:0] bal [ACCOUNTS];
  assign busy = state != IDLE;
  // walk downward from the farthest slot so the nearest requester after p is the last to win
  always_comb begin
    win_n = p;
    found = 1'b0;
    k = '0;
    for (int i = NUM_ATM - 1; i >= 0; i--) begin
      k = {1'b0, p} + (WW+1)'(i);
      if (k >= (WW+1)'(NUM_ATM)) k = k - (WW+1)'(NUM_ATM);
      if (req[k[WW-1:0]]) begin
        win_n = k[WW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state == IDLE  ? ((found && !init_we) ? LATCH : IDLE) :
              state == LATCH ? READ :
              state == READ  ? EXEC :
              state == EXEC  ? RESP : IDLE;
  end
  always_comb begin
    sum = {1'b0, work} + (BAL_W+1)'(amt);
    wr = 1'b0;
    st_n = 2'b00;
    res_n = work;
    if (op == 2'b00 || card == 8'h00) st_n = 2'b11;
    else if (op == 2'b01) begin
      if (sum[BAL_W]) st_n = 2'b10;
      else begin
        res_n = sum[BAL_W-1:0];
        wr = 1'b1;
      end
    end else if (op == 2'b10) begin
      if (BAL_W'(amt) > work) st_n = 2'b01;
      else begin
        res_n = work - BAL_W'(amt);
        wr = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      win <= '0;
      grant <= '0;
      done <= '0;
      resp_status <= 2'b00;
      resp_balance <= '0;
      op <= 2'b00;
      card <= 8'h00;
      amt <= '0;
      work <= '0;
      status <= 2'b00;
      result <= '0;
      for (int i = 0; i < ACCOUNTS; i++) bal[i] <= '0;
    end else begin
      done <= '0;
      if (state == IDLE) begin
        win <= win_n;
        if (init_we && init_card != 8'h00) bal[init_card[IW-1:0]] <= init_balance;
      end
      if (state == LATCH) begin
        grant <= NUM_ATM'(1) << win;
        op <= req_op[2*win +: 2];
        card <= req_card[8*win +: 8];
        amt <= req_amount[AMT_W*win +: AMT_W];
      end
      if (state == READ) work <= bal[card[IW-1:0]];
      if (state == EXEC) begin
        status <= st_n;
        result <= res_n;
        if (wr) bal[card[IW-1:0]] <= res_n;
      end
      if (state == RESP) begin
        done <= grant;
        grant <= '0;
        resp_status <= status;
        resp_balance <= result;
        p <= win == WW'(NUM_ATM - 1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule
